// File: rtl/l1i_refill_ctrl.sv
// l1i_refill_ctrl: L1 I-cache miss/next-line refill FSM; define L1I_NEXT_PREFETCH_EN to prefetch line+1 after each primary refill
module l1i_refill_ctrl #(
    parameter int block_size = 128,
    parameter int addr_size  = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_req_i,
    input  logic [addr_size-1:0]  fetch_addr_i,
    input  logic                  hit_i,
    input  logic                  miss_next_i,
    output logic                  stall_o,
    output logic                  l2_req_o,
    output logic [addr_size-1:0]  l2_addr_o,
    input  logic                  l2_valid_i,
    input  logic [block_size-1:0] l2_data_i,
    output logic                  instr_write_start_o,
    output logic                  write_o,
    output logic                  write_next_o,
    output logic [addr_size-1:0]  l1_addr_o,
    output logic [block_size-1:0] l1_data_o,
    output logic [15:0]           refill_cnt_o
);
    localparam int lw = addr_size - 3;
    typedef enum logic [2:0] {IDLE, REQ, FILL_SEL, FILL_WR, REPLAY} state_t;
    state_t                state_q;
    logic                  next_q;
    logic [lw-1:0]         line_q;
    logic [block_size-1:0] data_q;
    logic [lw-1:0]         line_d;
    logic                  miss;
    logic                  miss_nx;
    logic                  unused_offset;
    assign unused_offset = ^fetch_addr_i[2:0];
    assign miss    = fetch_req_i & ~hit_i;
    assign miss_nx = fetch_req_i & hit_i & miss_next_i;
    // a hit only starts a refill for the straddled next line, so hit_i doubles as the +1
    assign line_d  = fetch_addr_i[addr_size-1:3] + lw'(hit_i);
    assign stall_o = (state_q == IDLE) ? (miss | miss_nx) : (state_q != REPLAY);
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q             <= IDLE;
            next_q              <= 1'b0;
            line_q              <= '0;
            data_q              <= '0;
            l2_req_o            <= 1'b0;
            l2_addr_o           <= '0;
            instr_write_start_o <= 1'b0;
            write_o             <= 1'b0;
            write_next_o        <= 1'b0;
            l1_addr_o           <= '0;
            l1_data_o           <= '0;
            refill_cnt_o        <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss | miss_nx) begin
                    state_q   <= REQ;
                    line_q    <= line_d;
                    next_q    <= hit_i;
                    l2_req_o  <= 1'b1;
                    l2_addr_o <= {line_d, 3'b000};
                end
                REQ: if (l2_valid_i) begin
                    state_q             <= FILL_SEL;
                    data_q              <= l2_data_i;
                    l2_req_o            <= 1'b0;
                    instr_write_start_o <= 1'b1;
                    l1_addr_o           <= {line_q, 3'b000};
                end
                FILL_SEL: begin
                    state_q             <= FILL_WR;
                    instr_write_start_o <= 1'b0;
                    write_o             <= 1'b1;
                    write_next_o        <= next_q;
                    l1_data_o           <= data_q;
                end
                FILL_WR: begin
                    state_q      <= REPLAY;
                    write_o      <= 1'b0;
                    write_next_o <= 1'b0;
                    if (refill_cnt_o != 16'hFFFF) refill_cnt_o <= refill_cnt_o + 16'd1;
                end
                default: begin
`ifdef L1I_NEXT_PREFETCH_EN
                    if (!next_q) begin
                        state_q   <= REQ;
                        line_q    <= line_q + lw'(1);
                        next_q    <= 1'b1;
                        l2_req_o  <= 1'b1;
                        l2_addr_o <= {line_q + lw'(1), 3'b000};
                    end else begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1i_refill_ctrl.sv
// tb_l1i_refill_ctrl: randomized refill traffic against a line-level reference model with a write scoreboard
module tb_l1i_refill_ctrl;
    localparam int BS = 128;
    localparam int AS = 18;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          fetch_req_i = 1'b0;
    logic [AS-1:0] fetch_addr_i = '0;
    logic          hit_i = 1'b0;
    logic          miss_next_i = 1'b0;
    logic          l2_valid_i = 1'b0;
    logic [BS-1:0] l2_data_i = '0;
    logic          stall_o, l2_req_o, instr_write_start_o, write_o, write_next_o;
    logic [AS-1:0] l2_addr_o, l1_addr_o;
    logic [BS-1:0] l1_data_o;
    logic [15:0]   refill_cnt_o;

    l1i_refill_ctrl #(.block_size(BS), .addr_size(AS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .hit_i(hit_i), .miss_next_i(miss_next_i), .stall_o(stall_o), .l2_req_o(l2_req_o),
        .l2_addr_o(l2_addr_o), .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i),
        .instr_write_start_o(instr_write_start_o), .write_o(write_o), .write_next_o(write_next_o),
        .l1_addr_o(l1_addr_o), .l1_data_o(l1_data_o), .refill_cnt_o(refill_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AS-1:0] addr;
        logic          nxt;
        logic [BS-1:0] data;
        logic [15:0]   cnt;
    } exp_t;
    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;
    int   cnt_m = 0;

    task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BS-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic        cnt_pend = 1'b0;
    logic [15:0] cnt_exp_m = '0;
    always @(negedge clk_i) begin
        exp_t e;
        if (cnt_pend) chk("refill_cnt", BS'(refill_cnt_o), BS'(cnt_exp_m));
        cnt_pend <= 1'b0;
        if (write_o === 1'b1) begin
            if (exp_q.size() == 0) chk("write_without_refill", BS'(write_o), BS'(0));
            else begin
                e = exp_q.pop_front();
                chk("l1_addr", BS'(l1_addr_o), BS'(e.addr));
                chk("write_next", BS'(write_next_o), BS'(e.nxt));
                chk("l1_data", l1_data_o, e.data);
                cnt_pend  <= 1'b1;
                cnt_exp_m <= e.cnt;
            end
        end
    end

    task automatic serve(input int line, input bit nxt, input int lat);
        exp_t e;
        e.data = rnd_line();
        cnt_m  = (cnt_m == 65535) ? cnt_m : cnt_m + 1;
        e.addr = AS'(line * 8);
        e.nxt  = nxt;
        e.cnt  = 16'(cnt_m);
        exp_q.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk_i); #1;
            fetch_req_i  = (i < lat) ? 1'($urandom) : 1'b0;
            hit_i        = 1'($urandom);
            miss_next_i  = 1'($urandom);
            fetch_addr_i = AS'($urandom);
            l2_valid_i   = (i == lat);
            l2_data_i    = (i == lat) ? e.data : rnd_line();
            @(negedge clk_i);
            chk("l2_req", BS'(l2_req_o), BS'(1));
            chk("l2_addr", BS'(l2_addr_o), BS'(e.addr));
            chk("stall_req", BS'(stall_o), BS'(1));
        end
        @(posedge clk_i); #1;
        l2_valid_i  = 1'b0;
        fetch_req_i = 1'b0;
        l2_data_i   = rnd_line();
        @(negedge clk_i);
        chk("write_start", BS'(instr_write_start_o), BS'(1));
        chk("l2_req_sel", BS'(l2_req_o), BS'(0));
        chk("stall_sel", BS'(stall_o), BS'(1));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("write_start_wr", BS'(instr_write_start_o), BS'(0));
        chk("write", BS'(write_o), BS'(1));
        chk("stall_wr", BS'(stall_o), BS'(1));
        @(posedge clk_i); #1;
        l2_valid_i = 1'b1;
        l2_data_i  = rnd_line();
        @(negedge clk_i);
        chk("stall_replay", BS'(stall_o), BS'(0));
        chk("write_replay", BS'(write_o), BS'(0));
        chk("l2_req_replay", BS'(l2_req_o), BS'(0));
    endtask

    task automatic refill(input logic [AS-1:0] a, input bit h, input bit mn, input int lat);
        int line;
        bit go;
        go   = !h || mn;
        line = (int'(a) / 8 + (h ? 1 : 0)) % 32768;
        @(posedge clk_i); #1;
        fetch_req_i  = 1'b1;
        fetch_addr_i = a;
        hit_i        = h;
        miss_next_i  = mn;
        l2_valid_i   = 1'b0;
        @(negedge clk_i);
        chk("stall_idle", BS'(stall_o), BS'(go));
        if (!go) begin
            @(posedge clk_i); #1;
            fetch_req_i = 1'b0;
            @(negedge clk_i);
            chk("l2_req_on_hit", BS'(l2_req_o), BS'(0));
            chk("stall_after_hit", BS'(stall_o), BS'(0));
            return;
        end
        serve(line, h, lat);
`ifdef L1I_NEXT_PREFETCH_EN
        if (!h) serve((line + 1) % 32768, 1'b1, lat);
`endif
    endtask

    task automatic reset_abort();
        @(posedge clk_i); #1;
        fetch_req_i  = 1'b1;
        hit_i        = 1'b0;
        miss_next_i  = 1'b0;
        fetch_addr_i = AS'($urandom);
        l2_valid_i   = 1'b0;
        @(posedge clk_i); #1;
        fetch_req_i = 1'b0;
        @(negedge clk_i);
        chk("l2_req_pre_rst", BS'(l2_req_o), BS'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_l2_req", BS'(l2_req_o), BS'(0));
        chk("rst_stall", BS'(stall_o), BS'(0));
        chk("rst_cnt", BS'(refill_cnt_o), BS'(0));
        @(posedge clk_i); #1;
        rst_i      = 1'b1;
        l2_valid_i = 1'b1;
        l2_data_i  = rnd_line();
        cnt_m      = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("late_valid_write", BS'(write_o), BS'(0));
            chk("late_valid_start", BS'(instr_write_start_o), BS'(0));
            chk("late_valid_l2_req", BS'(l2_req_o), BS'(0));
            @(posedge clk_i); #1;
            l2_valid_i = (i == 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_stall", BS'(stall_o), BS'(0));
        chk("reset_l2_req", BS'(l2_req_o), BS'(0));
        chk("reset_l2_addr", BS'(l2_addr_o), BS'(0));
        chk("reset_write_start", BS'(instr_write_start_o), BS'(0));
        chk("reset_write", BS'(write_o), BS'(0));
        chk("reset_write_next", BS'(write_next_o), BS'(0));
        chk("reset_l1_addr", BS'(l1_addr_o), BS'(0));
        chk("reset_l1_data", l1_data_o, BS'(0));
        chk("reset_cnt", BS'(refill_cnt_o), BS'(0));
        rst_i = 1'b1;
        refill(18'h2A5B7, 1'b0, 1'b0, 4);
        refill(18'h0003F, 1'b1, 1'b1, 3);
        refill(18'h3FFFF, 1'b1, 1'b1, 2);
        refill(18'h12345, 1'b1, 1'b0, 1);
        refill(18'h1FFF8, 1'b0, 1'b1, 2);
        reset_abort();
        refill(18'h01230, 1'b0, 1'b0, 1);
        repeat (40) refill(AS'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 6));
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("pending_refills", BS'(exp_q.size()), BS'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
